// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage MIPS core: decodes PC / pipeline
// register enables and flushes, and keeps saturating stall and flush counters.
module hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_mem,
    input  logic             dmemWEN_mem,
    input  logic             memread_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             redirect_ex,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic data_wait;
    logic load_use;
    logic frozen;
    logic redirect_taken;
    logic stall_cycle;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use  = memread_ex && (rd_ex != '0) &&
                       ((rd_ex == rs_id) || (rd_ex == rt_id));
    assign data_wait = (dmemREN_mem || dmemWEN_mem) && !dhit;

    // Entering a data wait looks at the MEM access; staying frozen only at dhit.
    assign frozen = ((state_q == RUN) && data_wait) || ((state_q == DWAIT) && !dhit);

    always_comb begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        exmem_en       = 1'b1;
        memwb_en       = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        redirect_taken = 1'b0;
        state_d        = state_q;
        halt_d         = halt_q;

        case (state_q)
            RUN, DWAIT: begin
                if (halt_wb) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    state_d  = HALT;
                    halt_d   = 1'b1;
                end else if (frozen) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    state_d  = DWAIT;
                end else begin
                    state_d = RUN;
                    if (redirect_ex) begin
                        ifid_flush     = 1'b1;
                        idex_flush     = 1'b1;
                        redirect_taken = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
            end
            HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halt_d   = 1'b1;
            end
            default: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                state_d  = RUN;
            end
        endcase
    end

    // The cycle that raises halt is not a stall; it is the end of the program.
    assign stall_cycle = !pc_en && (state_q != HALT) && !halt_wb;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_cycle && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect_taken && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halt_out  = halt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int CW = 4;
    localparam int RW = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK;
    logic          nRST;
    logic          ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex;
    logic [RW-1:0] rd_ex, rs_id, rt_id;
    logic          redirect_ex, halt_wb;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, halt_out;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    state_dbg;
    logic [6:0]    strobes;

    int checks = 0;
    int failures = 0;

    assign strobes = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

    // Expected strobe patterns {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] S_NORMAL   = 7'b1111100;
    localparam logic [6:0] S_FROZEN   = 7'b0000000;
    localparam logic [6:0] S_REDIRECT = 7'b1111111;
    localparam logic [6:0] S_LOADUSE  = 7'b0011101;
    localparam logic [6:0] S_IMISS    = 7'b0111110;

    hazard_ctrl #(.CNT_W(CW), .REG_W(RW)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dmemREN_mem (dmemREN_mem),
        .dmemWEN_mem (dmemWEN_mem),
        .memread_ex  (memread_ex),
        .rd_ex       (rd_ex),
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .redirect_ex (redirect_ex),
        .halt_wb     (halt_wb),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .halt_out    (halt_out),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .state_dbg   (state_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic set_idle();
        ihit = 1'b1;
        dhit = 1'b1;
        dmemREN_mem = 1'b0;
        dmemWEN_mem = 1'b0;
        memread_ex = 1'b0;
        rd_ex = '0;
        rs_id = '0;
        rt_id = '0;
        redirect_ex = 1'b0;
        halt_wb = 1'b0;
    endtask

    task automatic set_random();
        ihit = ($urandom_range(0, 3) != 0);
        dhit = ($urandom_range(0, 4) > 1);
        dmemREN_mem = ($urandom_range(0, 3) == 0);
        dmemWEN_mem = ($urandom_range(0, 3) == 0);
        memread_ex = $urandom_range(0, 1);
        rd_ex = RW'($urandom_range(0, 3));
        rs_id = RW'($urandom_range(0, 3));
        rt_id = RW'($urandom_range(0, 3));
        redirect_ex = ($urandom_range(0, 4) == 0);
        halt_wb = ($urandom_range(0, 79) == 0);
    endtask

    // Leaves the bench 1 time unit after a falling edge with reset released.
    task automatic do_reset();
        set_idle();
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        set_idle();
        ihit = 1'b0;
        #3;
        checks++;
        if (strobes !== S_IMISS) begin
            failures++;
            $display("FAIL reset_decode got=%b exp=%b", strobes, S_IMISS);
        end
        @(negedge CLK);
        nRST = 1'b1;
        ihit = 1'b1;
        #1;
        checks++;
        if (halt_out !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
            failures++;
            $display("FAIL reset_regs got halt=%b stall=%0d flush=%0d exp 0/0/0",
                     halt_out, stall_cnt, flush_cnt);
        end
        checks++;
        if (strobes !== S_NORMAL) begin
            failures++;
            $display("FAIL reset_idle_strobes got=%b exp=%b", strobes, S_NORMAL);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        memread_ex = 1'b1;
        rd_ex = 5'd8;
        rs_id = 5'd8;
        rt_id = 5'd3;
        #1;
        checks++;
        if (strobes !== S_LOADUSE) begin
            failures++;
            $display("FAIL load_use_rs got=%b exp=%b", strobes, S_LOADUSE);
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL load_use_cnt_before got=%0d exp=0", stall_cnt);
        end
        step();
        checks++;
        if (stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL load_use_cnt_after got=%0d exp=1", stall_cnt);
        end
        rd_ex = 5'd0;
        rs_id = 5'd0;
        rt_id = 5'd0;
        #1;
        checks++;
        if (strobes !== S_NORMAL) begin
            failures++;
            $display("FAIL load_use_r0 got=%b exp=%b", strobes, S_NORMAL);
        end
        step();
        checks++;
        if (stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL load_use_r0_cnt got=%0d exp=1", stall_cnt);
        end
        rd_ex = 5'd17;
        rs_id = 5'd2;
        rt_id = 5'd17;
        #1;
        checks++;
        if (strobes !== S_LOADUSE) begin
            failures++;
            $display("FAIL load_use_rt got=%b exp=%b", strobes, S_LOADUSE);
        end
        memread_ex = 1'b0;
        #1;
        checks++;
        if (strobes !== S_NORMAL) begin
            failures++;
            $display("FAIL no_load_match got=%b exp=%b", strobes, S_NORMAL);
        end
    endtask

    task automatic test_redirect_miss();
        do_reset();
        redirect_ex = 1'b1;
        ihit = 1'b0;
        memread_ex = 1'b1;
        rd_ex = 5'd4;
        rs_id = 5'd4;
        #1;
        checks++;
        if (strobes !== S_REDIRECT) begin
            failures++;
            $display("FAIL redirect_miss got=%b exp=%b", strobes, S_REDIRECT);
        end
        step();
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL redirect_cnts got flush=%0d stall=%0d exp flush=1 stall=0",
                     flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_data_wait();
        do_reset();
        dmemREN_mem = 1'b1;
        dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (strobes !== S_FROZEN) begin
                failures++;
                $display("FAIL dwait_frozen cycle=%0d got=%b exp=%b", i, strobes, S_FROZEN);
            end
            step();
        end
        dhit = 1'b1;
        redirect_ex = 1'b1;
        #1;
        checks++;
        if (strobes !== S_REDIRECT) begin
            failures++;
            $display("FAIL dwait_release got=%b exp=%b", strobes, S_REDIRECT);
        end
        checks++;
        if (stall_cnt !== 4'd3) begin
            failures++;
            $display("FAIL dwait_stall_cnt got=%0d exp=3", stall_cnt);
        end
        step();
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin
            failures++;
            $display("FAIL dwait_after got flush=%0d stall=%0d exp flush=1 stall=3",
                     flush_cnt, stall_cnt);
        end
        // Back in RUN: no MEM access and dhit low must not freeze anything.
        set_idle();
        dhit = 1'b0;
        #1;
        checks++;
        if (strobes !== S_NORMAL) begin
            failures++;
            $display("FAIL dwait_back_to_run got=%b exp=%b", strobes, S_NORMAL);
        end
    endtask

    task automatic test_halt();
        do_reset();
        dmemWEN_mem = 1'b1;
        dhit = 1'b0;
        step();
        halt_wb = 1'b1;
        #1;
        checks++;
        if (strobes !== S_FROZEN || halt_out !== 1'b0) begin
            failures++;
            $display("FAIL halt_entry got strobes=%b halt=%b exp=%b halt=0",
                     strobes, halt_out, S_FROZEN);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            set_random();
            #1;
            checks++;
            if (strobes !== S_FROZEN || halt_out !== 1'b1 ||
                stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
                failures++;
                $display("FAIL halt_hold cycle=%0d got strobes=%b halt=%b stall=%0d flush=%0d exp %b 1 1 0",
                         i, strobes, halt_out, stall_cnt, flush_cnt, S_FROZEN);
            end
            step();
        end
        set_idle();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (halt_out !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0 || strobes !== S_NORMAL) begin
            failures++;
            $display("FAIL async_reset got halt=%b stall=%0d flush=%0d strobes=%b exp 0 0 0 %b",
                     halt_out, stall_cnt, flush_cnt, strobes, S_NORMAL);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        ihit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (int'(stall_cnt) !== ((i < CMAX) ? i : CMAX)) begin
                failures++;
                $display("FAIL stall_saturate cycle=%0d got=%0d exp=%0d",
                         i, stall_cnt, (i < CMAX) ? i : CMAX);
            end
        end
    endtask

    task automatic test_random();
        bit         m_frozen, m_halted, lu, dw, stall, flushed;
        int         m_stall, m_flush;
        logic [6:0] exp_s;
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            m_frozen = 0;
            m_halted = 0;
            m_stall = 0;
            m_flush = 0;
            for (int c = 0; c < 70; c++) begin
                set_random();
                #1;
                lu = memread_ex && (rd_ex != 0) && (rd_ex == rs_id || rd_ex == rt_id);
                dw = (dmemREN_mem || dmemWEN_mem) && !dhit;
                flushed = 0;
                if (m_halted || halt_wb) exp_s = S_FROZEN;
                else if (m_frozen ? !dhit : dw) exp_s = S_FROZEN;
                else if (redirect_ex) begin
                    exp_s = S_REDIRECT;
                    flushed = 1;
                end
                else if (lu) exp_s = S_LOADUSE;
                else if (!ihit) exp_s = S_IMISS;
                else exp_s = S_NORMAL;
                stall = !m_halted && !halt_wb && !exp_s[6];
                checks++;
                if (strobes !== exp_s) begin
                    failures++;
                    $display("FAIL rand_strobes blk=%0d cycle=%0d got=%b exp=%b",
                             blk, c, strobes, exp_s);
                end
                if (!m_halted) begin
                    if (halt_wb) m_halted = 1;
                    else m_frozen = m_frozen ? !dhit : dw;
                end
                if (stall && m_stall < CMAX) m_stall++;
                if (flushed && m_flush < CMAX) m_flush++;
                step();
                checks++;
                if (int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush ||
                    halt_out !== m_halted) begin
                    failures++;
                    $display("FAIL rand_regs blk=%0d cycle=%0d got stall=%0d flush=%0d halt=%b exp %0d %0d %b",
                             blk, c, stall_cnt, flush_cnt, halt_out, m_stall, m_flush, m_halted);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_miss();
        test_data_wait();
        test_halt();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sits beside the forwarding unit and drives the enable and flush strobes of the PC and the four pipeline registers. It resolves load-use stalls, EX-stage control redirects, instruction-cache misses, data-cache waits and program halt. It also keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of the performance counters
- REG_W, 5, register-index width
- CLK  in  1  system clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dmemREN_mem, dmemWEN_mem  in  1 each  MEM-stage instruction reads / writes data memory
- memread_ex  in  1  EX-stage instruction is a load
- rd_ex  in  REG_W  destination register of the EX-stage instruction
- rs_id, rt_id  in  REG_W  source registers of the ID-stage instruction
- redirect_ex  in  1  taken branch or jump resolved in EX
- halt_wb  in  1  HALT instruction in WB
- pc_en  out  1  PC may update
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables
- ifid_flush, idex_flush  out  1 each  load a bubble instead of data; meaningful only when the matching _en is 1
- halt_out  out  1  sticky halt indicator
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALT
- flush_cnt  out  CNT_W  accepted redirects

## Operation
- FSM states: RUN, DWAIT, HALT. The reset state is RUN.
- Strobe outputs are Mealy, decoded from the current state and inputs. Default strobe values:
  - all _en = 1
  - all _flush = 0
- Priority, highest first, evaluated in RUN:
  1. halt_wb: all _en = 0. Next state HALT.
  2. Data wait, when (dmemREN_mem | dmemWEN_mem) & !dhit: all _en = 0 and pc_en = 0. Next state DWAIT.
  3. redirect_ex: pc_en = 1, ifid_flush = 1, idex_flush = 1. Increment flush_cnt.
  4. Load-use, when memread_ex & rd_ex != 0 & (rd_ex == rs_id | rd_ex == rt_id): pc_en = 0, ifid_en = 0, idex_flush = 1. EX/MEM and MEM/WB advance.
  5. Instruction miss, when !ihit: pc_en = 0, ifid_flush = 1. All other registers advance.
- DWAIT:
  - While !dhit: all _en = 0.
  - When dhit: evaluate exactly as RUN with the data-wait term forced false, so a pending redirect, load-use or ihit condition is acted on in that same cycle. Next state RUN, or HALT if halt_wb.
  - redirect_ex and load-use are ignored while frozen. They are re-evaluated when the freeze releases.
- HALT:
  - All _en = 0, halt_out = 1. The state is absorbing until nRST.
- A register of 0 never causes a load-use stall.
- Counters:
  - stall_cnt increments on every cycle with pc_en = 0 while the state is not HALT and halt_wb = 0.
  - flush_cnt increments on every cycle in which a redirect is acted on.
  - Both saturate at 2^CNT_W − 1 and never wrap.

## Timing
- Strobe outputs are combinational, with zero-cycle latency from inputs. They are consumed at the same rising edge as the pipeline registers.
- State, counters and halt_out change only on a rising CLK edge or asynchronously on nRST.
- Reset values:
  - state RUN, halt_out 0, stall_cnt 0, flush_cnt 0
  - strobes follow the RUN decode of the current inputs
- nRST asserted mid-stall or in HALT returns the block to RUN immediately, without waiting for a clock edge.
- A load-use stall lasts exactly one cycle, because the bubble in EX clears the condition. A back-to-back load-use stall requires a new load.
- A data wait of N cycles with no dhit produces N frozen cycles plus the release cycle. stall_cnt increases by N, plus 1 if the release cycle itself stalls.
- Simultaneous dhit and redirect_ex in DWAIT: the redirect is acted on in that cycle and flush_cnt increments once.

## Test plan
- Load-use: memread_ex=1, rd_ex=8, rs_id=8, ihit=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, stall_cnt goes 0→1. The same stimulus with rd_ex=0 -> no stall.
- Redirect with miss: redirect_ex=1, ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt +1, stall_cnt unchanged.
- Data wait: dmemREN_mem=1, dhit=0 for 3 cycles, then dhit=1 with redirect_ex=1 -> 3 fully frozen cycles (stall_cnt=3), release cycle flushes IF/ID and ID/EX, state returns to RUN, flush_cnt=1.
- Halt: halt_wb=1 during a data wait -> all _en=0, halt_out=1 from the next edge and held for 10 cycles with any inputs. Asynchronous nRST low mid-cycle -> halt_out=0 and counters 0 immediately.
- Saturation: CNT_W=4, ihit=0 for 20 cycles -> stall_cnt holds at 15 and never wraps.
